fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Instruction fetch front-end that sits directly upstream of the decoder/immgen stage.
- Owns the fetch PC and issues word requests to instruction memory over a req/ack handshake.
- Buffers returned instructions with their PC in a small FIFO.
- Presents them to decode with a valid/ready handshake.
- A redirect (branch/jump) flushes the queue and restarts fetch at a new PC.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >= 2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high reset
o_imem_req  out  1  fetch request valid
o_imem_addr  out  32  word-aligned fetch address
i_imem_ack  in  1  memory returns i_imem_rdata this cycle; completes the request
i_imem_rdata  in  32  fetched instruction
i_redirect  in  1  flush and restart fetch
i_redirect_pc  in  32  new fetch PC; bits [1:0] forced to 0
o_instr_valid  out  1  o_instr/o_instr_pc valid
o_instr  out  32  instruction to decode/immgen; INSTR_NOP when not valid
o_instr_pc  out  32  PC of o_instr
i_instr_ready  in  1  decode accepts the head entry
o_full  out  1  count == DEPTH
o_empty  out  1  count == 0

Behaviour:
- Reset values: o_imem_req=0, o_imem_addr=RESET_PC, o_instr_valid=0, o_instr=INSTR_NOP, o_instr_pc=0, o_empty=1, o_full=0, count=0, state=IDLE.
- FSM states:
  - IDLE: no request outstanding.
  - REQ: o_imem_req=1, request outstanding.
  - DISCARD: o_imem_req=0; a stale request is still outstanding and its data will be dropped.
- Request handshake:
  - o_imem_addr equals the fetch PC and stays stable while REQ is waiting.
  - Exactly one request is outstanding at a time.
- IDLE -> REQ when count_next < DEPTH, or unconditionally on redirect.
- REQ, on ack:
  - Push {fetch_pc, rdata}; fetch_pc += 4 (wraps modulo 2^32).
  - Stay in REQ (back-to-back fetch) if count after this cycle's push/pop < DEPTH; else go to IDLE.
- REQ with redirect and no ack: fetch_pc <= redirect_pc; go to DISCARD.
- REQ with redirect and ack in the same cycle: ack data dropped; fetch_pc <= redirect_pc; stay in REQ.
- DISCARD:
  - On ack, drop data and go to REQ at the already-latched redirect PC.
  - A further redirect updates fetch_pc only.
- FIFO:
  - Pop when o_instr_valid && i_instr_ready.
  - Simultaneous push and pop leaves count unchanged.
  - Credit rule guarantees no push when full; an ack arriving in the full state is an assertion error.
- Redirect:
  - Clears the FIFO the same cycle (o_instr_valid=0 next cycle).
  - Overrides any push/pop in that cycle.
  - The head popped in the redirect cycle still counts as consumed.
- Latency: ack at cycle N -> o_instr_valid at N+1 (FIFO registered). Redirect at N -> first request for the new PC at N+1 (from IDLE/REQ), or the cycle after the stale ack (from DISCARD).
- Asynchronous reset mid-request: outstanding request abandoned; the memory model must tolerate a dropped request.

Optional Feature:
FETCH_Q_BYPASS_EN
- Defined: when the FIFO is empty, state is REQ, i_imem_ack=1 and no redirect, rdata/addr drive o_instr/o_instr_pc combinationally with o_instr_valid=1 in the same cycle.
  - If i_instr_ready=1, the entry is consumed and not pushed.
  - Otherwise it is pushed normally.
- Undefined: fixed 1-cycle latency through the FIFO; no combinational path from imem to decode outputs.

Decomposition:
- Package fetch_q_pkg:
  - typedef enum state_e {IDLE, REQ, DISCARD}
  - typedef struct packed fq_entry_t {pc[31:0], instr[31:0]}
  - localparam INSTR_NOP = 32'h0000_0013
  - localparam PC_STEP = 4
- Sub-module fq_fifo: synchronous FIFO of fq_entry_t with push, pop, flush, count, full, empty (the flush input takes priority).

Test Plan:
1. Reset, memory acks every cycle, i_instr_ready=1 -> requests at 0x0,0x4,0x8,0xC back-to-back; o_instr_pc 0x0.. one cycle after each ack; o_instr matches memory (e.g. 0xFE320493 at 0x0).
2. i_instr_ready=0, DEPTH=4 -> exactly 4 acks then o_imem_req=0, o_full=1; raise ready -> one pop then fetch resumes at 0x10.
3. Redirect to 0x103 while REQ waiting (ack 2 cycles later) -> state DISCARD, stale data dropped, next request addr 0x100, FIFO empty.
4. Redirect coincident with ack and pop -> ack data not queued, o_instr_valid=0 next cycle, next request 0x100.
5. i_reset asserted mid-request with 2 entries queued -> outputs immediately at reset values; after release first request at RESET_PC.
6. Wrap: redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000; with FETCH_Q_BYPASS_EN, empty queue and ready=1 -> o_instr_valid in the ack cycle.

Source files
------------

// File: rtl/fetch_q_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_q_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  // addi x0, x0, 0
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fq_fifo.sv
// Synchronous FIFO of {pc, instr} entries. Flush takes priority over push/pop.
module fq_fifo
  import fetch_q_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fq_entry_t                push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fq_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  fq_entry_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, issues one outstanding
// imem request at a time, buffers returned words and hands them to decode.
// Optional macro FETCH_Q_BYPASS_EN: an ack arriving while the queue is empty
// drives the decode outputs combinationally in the same cycle.
// o_state exposes the FSM state for debug.
//
// Handshakes: imem request is held (stable address) while o_imem_req=1 until
// a cycle with i_imem_ack=1 completes it; decode transfers a head entry on
// any cycle where o_instr_valid=1 and i_instr_ready=1.
module fetch_queue
  import fetch_q_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  input  logic        i_instr_ready,
  output logic        o_full,
  output logic        o_empty,
  output logic [1:0]  o_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e       state, state_next;
  logic [31:0]  fetch_pc, fetch_pc_next;
  logic [31:0]  redirect_pc;
  logic         ack_ok;
  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0]  count_after;
  fq_entry_t    head;
  fq_entry_t    push_data;

  assign redirect_pc = {i_redirect_pc[31:2], 2'b00};
  assign push_data   = '{pc: fetch_pc, instr: i_imem_rdata};

  fq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (i_clk),
    .rst       (i_reset),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .flush     (i_redirect),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Push/pop decisions and the decode-facing output mux.
  always_comb begin
    ack_ok   = (state == REQ) && i_imem_ack && !i_redirect;
    fifo_pop = !fifo_empty && i_instr_ready;
    o_instr       = INSTR_NOP;
    o_instr_pc    = 32'h0;
`ifdef FETCH_Q_BYPASS_EN
    // Empty queue: the returning word goes straight to decode; it is queued
    // only if decode does not take it this cycle.
    fifo_push     = ack_ok && !(fifo_empty && i_instr_ready);
    o_instr_valid = !fifo_empty || ack_ok;
    if (!fifo_empty) begin
      o_instr    = head.instr;
      o_instr_pc = head.pc;
    end else if (ack_ok) begin
      o_instr    = i_imem_rdata;
      o_instr_pc = fetch_pc;
    end
`else
    fifo_push     = ack_ok;
    o_instr_valid = !fifo_empty;
    if (!fifo_empty) begin
      o_instr    = head.instr;
      o_instr_pc = head.pc;
    end
`endif
    count_after = {1'b0, fifo_count} + {{CW{1'b0}}, fifo_push}
                - {{CW{1'b0}}, fifo_pop};
  end

  // Next-state and next fetch PC; a redirect always wins over a data return.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    case (state)
      IDLE: begin
        if (i_redirect) begin
          fetch_pc_next = redirect_pc;
          state_next    = REQ;
        end else if (count_after < (CW + 1)'(DEPTH)) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (i_redirect) begin
          fetch_pc_next = redirect_pc;
          state_next    = i_imem_ack ? REQ : DISCARD;
        end else if (i_imem_ack) begin
          fetch_pc_next = fetch_pc + PC_STEP;
          state_next    = (count_after < (CW + 1)'(DEPTH)) ? REQ : IDLE;
        end
      end
      DISCARD: begin
        if (i_redirect) fetch_pc_next = redirect_pc;
        if (i_imem_ack) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and fetch PC registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
    end
  end

  // Credit flow never lets a word arrive with the queue already full.
  always_ff @(posedge i_clk) begin
    if (!i_reset) assert (!(i_imem_ack && fifo_full && !i_redirect));
  end

  assign o_imem_req  = (state == REQ);
  assign o_imem_addr = fetch_pc;
  assign o_full      = fifo_full;
  assign o_empty     = fifo_empty;
  assign o_state     = state;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a scoreboard of expected {pc, instr}.
module tb_fetch_queue;
  import fetch_q_pkg::*;

`ifdef FETCH_Q_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        i_instr_ready = 1'b0;
  logic        o_full;
  logic        o_empty;
  logic [1:0]  o_state;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_pc = 32'h0;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ack    (i_imem_ack),
    .i_imem_rdata  (i_imem_rdata),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_instr_valid (o_instr_valid),
    .o_instr       (o_instr),
    .o_instr_pc    (o_instr_pc),
    .i_instr_ready (i_instr_ready),
    .o_full        (o_full),
    .o_empty       (o_empty),
    .o_state       (o_state)
  );

  // clock
  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'hFE32_0493;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset();
    chk("rst_req",   64'(o_imem_req),    64'd0);
    chk("rst_addr",  64'(o_imem_addr),   64'h0);
    chk("rst_valid", 64'(o_instr_valid), 64'd0);
    chk("rst_instr", 64'(o_instr),       64'(INSTR_NOP));
    chk("rst_pc",    64'(o_instr_pc),    64'h0);
    chk("rst_empty", 64'(o_empty),       64'd1);
    chk("rst_full",  64'(o_full),        64'd0);
    chk("rst_state", 64'(o_state),       64'(IDLE));
  endtask

  // One clock: drive inputs now, check/score mid-cycle, return just after the edge.
  task automatic step(input logic ack, input logic rdy, input logic redir,
                      input logic [31:0] rpc, input logic [31:0] rdata);
    logic        accepted;
    logic        exp_valid;
    int          sz;
    logic [63:0] ent;
    i_imem_ack    = ack;
    i_imem_rdata  = rdata;
    i_instr_ready = rdy;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    @(negedge i_clk);
    sz = exp_q.size();
    accepted = ack && o_imem_req && !redir;
    chk("empty", 64'(o_empty), 64'(sz == 0));
    if (accepted) begin
      chk("imem_addr", 64'(o_imem_addr), 64'(exp_pc));
      exp_q.push_back({exp_pc, rdata});
      exp_pc = exp_pc + 32'd4;
    end
    exp_valid = (sz > 0) || (BYPASS && accepted);
    chk("instr_valid", 64'(o_instr_valid), 64'(exp_valid));
    if (!o_instr_valid) chk("nop", 64'(o_instr), 64'(INSTR_NOP));
    if (o_instr_valid && rdy) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 64'(o_instr_valid), 64'd0);
      end else begin
        ent = exp_q.pop_front();
        chk("pop_pc",    64'(o_instr_pc), 64'(ent[63:32]));
        chk("pop_instr", 64'(o_instr),    64'(ent[31:0]));
      end
    end
    if (redir) begin
      exp_q.delete();
      exp_pc = {rpc[31:2], 2'b00};
    end
    @(posedge i_clk);
    #1;
    i_imem_ack = 1'b0;
    i_redirect = 1'b0;
  endtask

  // Memory answers every outstanding request immediately.
  task automatic fetch_cycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(o_imem_req, rdy, 1'b0, 32'h0, mem_word(exp_pc));
  endtask

  task automatic idle_cycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, rdy, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    // reset
    repeat (3) @(posedge i_clk);
    #1;
    check_reset();
    i_reset = 1'b0;

    // T1: back-to-back fetch from RESET_PC with decode always ready
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("t1_req_up", 64'(o_imem_req), 64'd1);
    fetch_cycles(4, 1'b1);
    idle_cycles(2, 1'b1);

    // T2: decode stalled, queue fills and requests stop
    fetch_cycles(6, 1'b0);
    chk("t2_req_off", 64'(o_imem_req), 64'd0);
    chk("t2_full",    64'(o_full),     64'd1);
    chk("t2_state",   64'(o_state),    64'(IDLE));
    idle_cycles(1, 1'b1);
    chk("t2_resume_req",  64'(o_imem_req),  64'd1);
    chk("t2_resume_addr", 64'(o_imem_addr), 64'(exp_pc));
    idle_cycles(4, 1'b1);

    // T3: redirect while a request waits, stale ack two cycles later
    step(1'b0, 1'b1, 1'b1, 32'h0000_0103, 32'h0);
    chk("t3_discard", 64'(o_state),    64'(DISCARD));
    chk("t3_req_off", 64'(o_imem_req), 64'd0);
    idle_cycles(1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF);
    chk("t3_state", 64'(o_state),     64'(REQ));
    chk("t3_addr",  64'(o_imem_addr), 64'h0000_0100);
    chk("t3_empty", 64'(o_empty),     64'd1);

    // T4: redirect coincident with ack and pop
    fetch_cycles(2, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0100, mem_word(exp_pc));
    chk("t4_valid", 64'(o_instr_valid), 64'd0);
    chk("t4_addr",  64'(o_imem_addr),   64'h0000_0100);
    chk("t4_state", 64'(o_state),       64'(REQ));
    fetch_cycles(2, 1'b1);
    idle_cycles(2, 1'b1);

    // T5: asynchronous reset mid-request with two entries queued
    fetch_cycles(2, 1'b0);
    chk("t5_queued", 64'(o_empty), 64'd0);
    i_reset = 1'b1;
    #1;
    check_reset();
    exp_q.delete();
    exp_pc = 32'h0;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    idle_cycles(1, 1'b1);
    chk("t5_addr", 64'(o_imem_addr), 64'h0);
    fetch_cycles(1, 1'b1);
    idle_cycles(1, 1'b1);

    // T6: PC wraps past the top of the address space
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0BAD_0BAD);
    chk("t6_addr", 64'(o_imem_addr), 64'hFFFF_FFFC);
    fetch_cycles(3, 1'b1);
    idle_cycles(2, 1'b1);
    chk("t6_drained", 64'(exp_q.size()), 64'(o_empty ? 0 : 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
